// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC select, IF/ID register and
// a stall hold buffer. The instruction memory is synchronous, so the data for
// im_addr arrives one cycle later; the hold buffer captures it on the first
// stall cycle so that ID keeps seeing the same instruction.
// Optional build macro: FETCH_STATS_EN adds saturating fetch/stall/flush counters.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  branch_ctrl,
   input  logic [31:0] pc_imm_target,
   input  logic [31:0] pc_imm_rs1_target,
   input  logic        pc_write,
   input  logic        instr_flush,
   input  logic        if_id_reg_write,
   output logic [31:0] im_addr,
   input  logic [31:0] im_rdata,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_instr,
`ifdef FETCH_STATS_EN
   output logic [31:0] stat_fetch,
   output logic [31:0] stat_stall,
   output logic [31:0] stat_flush,
`endif
   output logic        if_id_valid
);

   logic [31:0] pc_q, pc_d, pc_next;
   logic [31:0] if_id_pc_q, if_id_pc_d;
   logic        if_id_valid_q, if_id_valid_d;
   logic [31:0] hold_q, hold_d;
   logic        hold_valid_q, hold_valid_d;

   // Next-PC select; the reserved encoding falls back to sequential fetch.
   always_comb begin
      pc_next = pc_q + 32'd4;
      case (branch_ctrl)
         2'b01:   pc_next = pc_imm_target;
         2'b10:   pc_next = pc_imm_rs1_target & ~32'h1;
         default: pc_next = pc_q + 32'd4;
      endcase
      pc_d = pc_write ? pc_next : pc_q;
   end

   // IF/ID update: flush beats load, load beats stall.
   always_comb begin
      if_id_pc_d    = if_id_pc_q;
      if_id_valid_d = if_id_valid_q;
      hold_d        = hold_q;
      hold_valid_d  = hold_valid_q;
      if (instr_flush) begin
         if_id_pc_d    = pc_q;
         if_id_valid_d = 1'b0;
         hold_valid_d  = 1'b0;
      end else if (if_id_reg_write) begin
         if_id_pc_d    = pc_q;
         if_id_valid_d = 1'b1;
         hold_valid_d  = 1'b0;
      end else if (!hold_valid_q) begin
         // Only the first stall cycle captures; later cycles would see the next word.
         hold_d       = im_rdata;
         hold_valid_d = 1'b1;
      end
   end

   // Pipeline state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q          <= RESET_PC;
         if_id_pc_q    <= 32'h0;
         if_id_valid_q <= 1'b0;
         hold_q        <= 32'h0;
         hold_valid_q  <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         if_id_pc_q    <= if_id_pc_d;
         if_id_valid_q <= if_id_valid_d;
         hold_q        <= hold_d;
         hold_valid_q  <= hold_valid_d;
      end
   end

   // Output drive and ID instruction select.
   always_comb begin
      im_addr     = pc_q;
      if_id_pc    = if_id_pc_q;
      if_id_valid = if_id_valid_q;
      if (!if_id_valid_q) begin
         if_id_instr = NOP_INSTR;
      end else if (hold_valid_q) begin
         if_id_instr = hold_q;
      end else begin
         if_id_instr = im_rdata;
      end
   end

`ifdef FETCH_STATS_EN
   logic [31:0] stat_fetch_q, stat_fetch_d;
   logic [31:0] stat_stall_q, stat_stall_d;
   logic [31:0] stat_flush_q, stat_flush_d;

   // Saturating event counters, classified by the same IF/ID priority.
   always_comb begin
      stat_fetch_d = stat_fetch_q;
      stat_stall_d = stat_stall_q;
      stat_flush_d = stat_flush_q;
      if (instr_flush) begin
         if (stat_flush_q != 32'hFFFF_FFFF) stat_flush_d = stat_flush_q + 32'd1;
      end else if (if_id_reg_write) begin
         if (stat_fetch_q != 32'hFFFF_FFFF) stat_fetch_d = stat_fetch_q + 32'd1;
      end else begin
         if (stat_stall_q != 32'hFFFF_FFFF) stat_stall_d = stat_stall_q + 32'd1;
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_fetch_q <= 32'h0;
         stat_stall_q <= 32'h0;
         stat_flush_q <= 32'h0;
      end else begin
         stat_fetch_q <= stat_fetch_d;
         stat_stall_q <= stat_stall_d;
         stat_flush_q <= stat_flush_d;
      end
   end

   assign stat_fetch = stat_fetch_q;
   assign stat_stall = stat_stall_q;
   assign stat_flush = stat_flush_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a synchronous IM model, a queue of expected
// IF/ID snapshots pushed when each step is driven and popped after the edge.
module tb_fetch_stage;

   logic        clk;
   logic        rst_n;
   logic [1:0]  branch_ctrl;
   logic [31:0] pc_imm_target;
   logic [31:0] pc_imm_rs1_target;
   logic        pc_write;
   logic        instr_flush;
   logic        if_id_reg_write;
   logic [31:0] im_addr;
   logic [31:0] im_rdata;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instr;
   logic        if_id_valid;
   logic [31:0] w_im_addr, w_if_id_pc, w_if_id_instr;
   logic        w_if_id_valid;
`ifdef FETCH_STATS_EN
   logic [31:0] stat_fetch, stat_stall, stat_flush;
   logic [31:0] w_stat_fetch, w_stat_stall, w_stat_flush;
`endif

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       tag;
      logic [31:0] addr;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        valid;
   } exp_t;

   exp_t sb_q[$];

   fetch_stage u_dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .branch_ctrl       (branch_ctrl),
      .pc_imm_target     (pc_imm_target),
      .pc_imm_rs1_target (pc_imm_rs1_target),
      .pc_write          (pc_write),
      .instr_flush       (instr_flush),
      .if_id_reg_write   (if_id_reg_write),
      .im_addr           (im_addr),
      .im_rdata          (im_rdata),
      .if_id_pc          (if_id_pc),
      .if_id_instr       (if_id_instr),
`ifdef FETCH_STATS_EN
      .stat_fetch        (stat_fetch),
      .stat_stall        (stat_stall),
      .stat_flush        (stat_flush),
`endif
      .if_id_valid       (if_id_valid)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
      .clk               (clk),
      .rst_n             (rst_n),
      .branch_ctrl       (branch_ctrl),
      .pc_imm_target     (pc_imm_target),
      .pc_imm_rs1_target (pc_imm_rs1_target),
      .pc_write          (pc_write),
      .instr_flush       (instr_flush),
      .if_id_reg_write   (if_id_reg_write),
      .im_addr           (w_im_addr),
      .im_rdata          (im_rdata),
      .if_id_pc          (w_if_id_pc),
      .if_id_instr       (w_if_id_instr),
`ifdef FETCH_STATS_EN
      .stat_fetch        (w_stat_fetch),
      .stat_stall        (w_stat_stall),
      .stat_flush        (w_stat_flush),
`endif
      .if_id_valid       (w_if_id_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory contents.
   function automatic logic [31:0] mem(input logic [31:0] a);
      case (a)
         32'h0:   mem = 32'h0050_0093;
         32'h4:   mem = 32'h0040_0113;
         32'h8:   mem = 32'h0000_A103;
         32'hC:   mem = 32'h0020_8233;
         default: mem = {a[23:0], 8'h13};
      endcase
   endfunction

   // Synchronous IM: data for an address appears the following cycle.
   always @(posedge clk) im_rdata <= mem(im_addr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of controls, queue the expected post-edge view, then compare.
   task automatic step(input string tag, input logic [1:0] bc, input logic pw,
                       input logic fl, input logic iw, input logic [31:0] e_addr,
                       input logic [31:0] e_pc, input logic [31:0] e_instr,
                       input logic e_valid);
      exp_t e;
      exp_t o;
      branch_ctrl     = bc;
      pc_write        = pw;
      instr_flush     = fl;
      if_id_reg_write = iw;
      e.tag = tag; e.addr = e_addr; e.pc = e_pc; e.instr = e_instr; e.valid = e_valid;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      o = sb_q.pop_front();
      chk({o.tag, ".im_addr"}, im_addr, o.addr);
      chk({o.tag, ".if_id_pc"}, if_id_pc, o.pc);
      chk({o.tag, ".if_id_instr"}, if_id_instr, o.instr);
      chk({o.tag, ".if_id_valid"}, {31'h0, if_id_valid}, {31'h0, o.valid});
   endtask

   initial begin
      rst_n             = 1'b0;
      branch_ctrl       = 2'b00;
      pc_imm_target     = 32'h0;
      pc_imm_rs1_target = 32'h0;
      pc_write          = 1'b1;
      instr_flush       = 1'b0;
      if_id_reg_write   = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      chk("reset.im_addr", im_addr, 32'h0);
      chk("reset.if_id_pc", if_id_pc, 32'h0);
      chk("reset.if_id_instr", if_id_instr, 32'h0000_0013);
      chk("reset.if_id_valid", {31'h0, if_id_valid}, 32'h0);
      chk("wrap.reset_addr", w_im_addr, 32'hFFFF_FFFC);
`ifdef FETCH_STATS_EN
      chk("stats.reset_fetch", stat_fetch, 32'h0);
`endif
      rst_n = 1'b1;

      step("first", 2'b00, 1'b1, 1'b0, 1'b1, 32'h4, 32'h0, 32'h0050_0093, 1'b1);
      chk("wrap.after_one", w_im_addr, 32'h0);
      step("seq1", 2'b00, 1'b1, 1'b0, 1'b1, 32'h8, 32'h4, 32'h0040_0113, 1'b1);
      step("seq_rsvd", 2'b11, 1'b1, 1'b0, 1'b1, 32'hC, 32'h8, 32'h0000_A103, 1'b1);

      // Load-use stall for two cycles, then release.
      step("stall1", 2'b00, 1'b0, 1'b0, 1'b0, 32'hC, 32'h8, 32'h0000_A103, 1'b1);
      step("stall2", 2'b00, 1'b0, 1'b0, 1'b0, 32'hC, 32'h8, 32'h0000_A103, 1'b1);
      step("release", 2'b00, 1'b1, 1'b0, 1'b1, 32'h10, 32'hC, 32'h0020_8233, 1'b1);

      // Branch redirect: one bubble then the target.
      pc_imm_target = 32'h100;
      step("branch", 2'b01, 1'b1, 1'b1, 1'b1, 32'h100, 32'h10, 32'h0000_0013, 1'b0);
      step("br_target", 2'b00, 1'b1, 1'b0, 1'b1, 32'h104, 32'h100, mem(32'h100), 1'b1);

      // Fill the hold buffer, then JALR flush while stalling must clear it.
      step("pre_jalr", 2'b00, 1'b0, 1'b0, 1'b0, 32'h104, 32'h100, mem(32'h100), 1'b1);
      pc_imm_rs1_target = 32'h203;
      step("jalr", 2'b10, 1'b1, 1'b1, 1'b0, 32'h202, 32'h104, 32'h0000_0013, 1'b0);
      step("jalr_target", 2'b00, 1'b1, 1'b0, 1'b1, 32'h206, 32'h202, mem(32'h202), 1'b1);

      // PC advances while IF/ID stalls: the word at 0x206 is skipped.
      step("pw_stall", 2'b00, 1'b1, 1'b0, 1'b0, 32'h20A, 32'h202, mem(32'h202), 1'b1);
      step("pw_resume", 2'b00, 1'b1, 1'b0, 1'b1, 32'h20E, 32'h20A, mem(32'h20A), 1'b1);

      // Stall to make the hold buffer valid, then reset in the middle of it.
      step("pre_rst", 2'b00, 1'b0, 1'b0, 1'b0, 32'h20E, 32'h20A, mem(32'h20A), 1'b1);
`ifdef FETCH_STATS_EN
      chk("stats.fetch", stat_fetch, 32'd7);
      chk("stats.stall", stat_stall, 32'd5);
      chk("stats.flush", stat_flush, 32'd2);
`endif
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst.im_addr", im_addr, 32'h0);
      chk("midrst.if_id_pc", if_id_pc, 32'h0);
      chk("midrst.if_id_instr", if_id_instr, 32'h0000_0013);
      chk("midrst.if_id_valid", {31'h0, if_id_valid}, 32'h0);
`ifdef FETCH_STATS_EN
      chk("midrst.stat_stall", stat_stall, 32'h0);
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step("post_rst", 2'b00, 1'b1, 1'b0, 1'b1, 32'h4, 32'h0, 32'h0050_0093, 1'b1);
      step("post_rst2", 2'b00, 1'b1, 1'b0, 1'b1, 32'h8, 32'h4, 32'h0040_0113, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
